sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares the single 8-bit external SRAM between the CPU (16-bit word rd/wr) and the VGA text fetcher
//  (16-bit char/attr word, read-only). Each word access is sequenced as two byte phases (low byte first).
//  Sits between control_unit/vga_display and the top-level SRAM pins; the tristate is resolved at top level.
// PARAMETERS
//  ACCESS_CYCLES  2         clocks per byte phase (>=2); sets SRAM strobe width
//  VIDEO_BASE     21'h1F0000  SRAM byte address of video word 0
// PORTS
//  clk           in   1   system clock (global_clk domain)
//  rst           in   1   synchronous, active-high reset
//  cpu_addr      in   16  CPU word address; held stable while cpu_rd/cpu_wr high
//  cpu_wdata     in   16  CPU write data; held stable while cpu_wr high
//  cpu_rd        in   1   CPU read request, level, held until cpu_ack
//  cpu_wr        in   1   CPU write request, level, held until cpu_ack
//  cpu_rdata     out  16  CPU read data; valid in cpu_ack cycle, held until next CPU read completes
//  cpu_ack       out  1   one-cycle completion pulse
//  vid_addr      in   12  video word address (0..1999)
//  vid_req       in   1   video read request, level, held until vid_ack
//  vid_rdata     out  16  video read data; valid in vid_ack cycle, held until next video read
//  vid_ack       out  1   one-cycle completion pulse
//  sram_addr     out  21  SRAM byte address
//  sram_dout     out  8   write byte to SRAM
//  sram_dout_en  out  1   1 = top level drives sram_data with sram_dout
//  sram_din      in   8   byte read from SRAM pins
//  sram_ce       out  1   chip enable, active low
//  sram_oe       out  1   output enable, active low
//  sram_we       out  1   write enable, active low
// BEHAVIOUR
//  Reset: FSM=IDLE, sram_ce/oe/we=1, sram_dout_en=0, sram_addr=0, cpu_ack=vid_ack=0, rdata regs=0,
//   last_grant=CPU (so video wins the first tie).
//  FSM: IDLE -> LO -> HI -> ACK -> IDLE. LO and HI each last exactly ACCESS_CYCLES clocks; ACK is 1 clock.
//  IDLE: sample requests each clock. Only one pending -> grant it. Both pending -> grant the port that
//   is NOT last_grant (strict alternation; neither starves). Grant latches port, op, address, wdata.
//  Latency: request sampled at edge k -> ack high in cycle k+1+2*ACCESS_CYCLES (AC=2: 5 clocks).
//   Back-to-back: next grant sampled in the IDLE cycle following ACK (min 2*AC+2 clocks per word).
//  Byte address: CPU = {4'b0, cpu_addr, b}; video = VIDEO_BASE + {8'b0, vid_addr, b}; b=0 in LO, 1 in HI.
//   CPU arithmetic is concatenation (no wrap); video add is 21-bit modulo.
//  Read phase: ce=0, oe=0, we=1, dout_en=0 for whole phase; sram_din captured on last phase clock
//   into [7:0] (LO) or [15:8] (HI) of the granted port's rdata register.
//  Write phase: ce=0, oe=1, dout_en=1, sram_dout = wdata[7:0] (LO) / [15:8] (HI) for whole phase;
//   we=0 only on phase clocks 1..AC-1 (clock 0 = address/data setup, we rises before addr changes).
//  ACK: ce/oe/we=1, dout_en=0; pulse the granted port's ack; update last_grant.
//  cpu_rd and cpu_wr both high: treated as write (illegal; bench asserts it never happens).
//  Request dropped after grant: access completes and ack still pulses; no abort.
//  Ungranted port's rdata/ack untouched during the other port's access.
//  Reset mid-access: back to IDLE on next edge, strobes deasserted, no ack, partial rdata discarded
//   (rdata regs reset to 0).
//  All outputs registered; no combinational path from request inputs to SRAM pins or acks.
// STRUCTURE
//  f64_mem_pkg: FSM state enum (IDLE/LO/HI/ACK), port-select enum (PORT_CPU/PORT_VID),
//   SRAM_AW=21, SRAM_DW=8, default VIDEO_BASE.
//  One sub-module: sram_phase_timer -- counter 0..ACCESS_CYCLES-1 with first/last flags; restarts on
//   phase entry; drives we-window and capture strobe.
// TESTING (SRAM behavioural model, AC=2, VIDEO_BASE=21'h1F0000)
//  1 CPU write 16'hBEEF @16'h0010 -> bytes 8'hEF @21'h20, 8'hBE @21'h21; we low 1 clk/byte; ack at k+5.
//  2 CPU read @16'h0010 after (1) -> cpu_rdata=16'hBEEF in ack cycle; oe low 4 clks, we never low.
//  3 vid_req @12'd5, model holds 16'h0748 at 21'h1F000A/B -> vid_rdata=16'h0748, cpu_rdata unchanged.
//  4 cpu_rd and vid_req raised same clock, both held for 3 words each -> grants V,C,V,C,V,C; no starvation.
//  5 rst pulsed during HI of a CPU write -> strobes high next clk, no cpu_ack, FSM IDLE, only LO byte written.
//  6 vid_req dropped one clock after grant -> access completes, single vid_ack, then IDLE.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
package sram_arbiter_pkg;
  localparam int SRAM_AW = 21;
  localparam int SRAM_DW = 8;
  localparam logic [SRAM_AW-1:0] VIDEO_BASE_DEFAULT = 21'h1F0000;

  typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_ACK} state_e;
  typedef enum logic {PORT_CPU, PORT_VID} port_e;

  // Byte address of the low byte of a CPU word (pure concatenation, no wrap).
  function automatic logic [SRAM_AW-1:0] cpu_byte_addr(input logic [15:0] wa);
    return {4'b0, wa, 1'b0};
  endfunction

  // Byte address of the low byte of a video word (21-bit modulo add).
  function automatic logic [SRAM_AW-1:0] vid_byte_addr(input logic [SRAM_AW-1:0] base,
                                                        input logic [11:0] wa);
    return base + {8'b0, wa, 1'b0};
  endfunction
endpackage

// File: rtl/sram_arbiter_if.sv
// Client request/response and SRAM pin bundle around the arbiter.
interface sram_arbiter_if;
  import sram_arbiter_pkg::*;

  logic [15:0]        cpu_addr;
  logic [15:0]        cpu_wdata;
  logic               cpu_rd;
  logic               cpu_wr;
  logic [15:0]        cpu_rdata;
  logic               cpu_ack;
  logic [11:0]        vid_addr;
  logic               vid_req;
  logic [15:0]        vid_rdata;
  logic               vid_ack;
  logic [SRAM_AW-1:0] sram_addr;
  logic [SRAM_DW-1:0] sram_dout;
  logic               sram_dout_en;
  logic [SRAM_DW-1:0] sram_din;
  logic               sram_ce;
  logic               sram_oe;
  logic               sram_we;

  // Arbiter side.
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, vid_addr, vid_req, sram_din,
    output cpu_rdata, cpu_ack, vid_rdata, vid_ack,
           sram_addr, sram_dout, sram_dout_en, sram_ce, sram_oe, sram_we
  );

  // Clients plus SRAM pins side.
  modport master (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, vid_addr, vid_req, sram_din,
    input  cpu_rdata, cpu_ack, vid_rdata, vid_ack,
           sram_addr, sram_dout, sram_dout_en, sram_ce, sram_oe, sram_we
  );
endinterface

// File: rtl/sram_arbiter_phase_timer.sv
// Byte-phase timer: counts 0..ACCESS_CYCLES-1 while a phase runs and wraps
// to 0 on the last clock, so every phase entry starts from clock 0.
module sram_phase_timer #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,     // high while in a byte phase
  output logic we_win_o,  // next clock stays in this phase (write strobe window)
  output logic cap_o      // current clock is the last of the phase
);
  localparam int CW = $clog2(ACCESS_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Advance within a phase; idle and the last clock both return to 0.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run_i || cnt_q == LAST) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cap_o    = (cnt_q == LAST);
  assign we_win_o = !cap_o;
endmodule

// File: rtl/sram_arbiter.sv
// Two-port (CPU rd/wr, video rd) arbiter for an 8-bit SRAM. Each 16-bit word
// is two byte phases, low byte first. All outputs come straight from flops.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int                 ACCESS_CYCLES = 2,
  parameter logic [SRAM_AW-1:0] VIDEO_BASE    = VIDEO_BASE_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  bus
);
  state_e             state_q;
  port_e              port_q, last_q;
  logic               wr_q;
  logic [SRAM_AW-1:0] base_q;
  logic [7:0]         wdata_hi_q;
  logic [7:0]         rd_lo_q;
  logic [15:0]        cpu_rdata_q, vid_rdata_q;
  logic               cpu_ack_q, vid_ack_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [SRAM_DW-1:0] dout_q;
  logic               dout_en_q, ce_q, oe_q, we_q;

  logic               cpu_req;
  logic               gnt_vld_d;
  port_e              gnt_port_d;
  logic               gnt_wr_d;
  logic [SRAM_AW-1:0] gnt_base_d;
  logic               we_win, cap;

  sram_phase_timer #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run_i    ((state_q == ST_LO) || (state_q == ST_HI)),
    .we_win_o (we_win),
    .cap_o    (cap)
  );

  // Grant selection: a lone request wins; on a tie the port not served last wins.
  always_comb begin
    cpu_req    = bus.cpu_rd | bus.cpu_wr;
    gnt_vld_d  = cpu_req | bus.vid_req;
    gnt_port_d = PORT_CPU;
    if (bus.vid_req && (!cpu_req || last_q == PORT_CPU)) gnt_port_d = PORT_VID;
    // rd+wr together is illegal; it falls through as a write.
    gnt_wr_d   = (gnt_port_d == PORT_CPU) && bus.cpu_wr;
    gnt_base_d = (gnt_port_d == PORT_CPU) ? cpu_byte_addr(bus.cpu_addr)
                                          : vid_byte_addr(VIDEO_BASE, bus.vid_addr);
  end

  // Access sequencer: IDLE -> LO -> HI -> ACK, strobes registered one clock ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      port_q      <= PORT_CPU;
      last_q      <= PORT_CPU;
      wr_q        <= 1'b0;
      base_q      <= '0;
      wdata_hi_q  <= '0;
      rd_lo_q     <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      dout_en_q   <= 1'b0;
      ce_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld_d) begin
            state_q    <= ST_LO;
            port_q     <= gnt_port_d;
            wr_q       <= gnt_wr_d;
            base_q     <= gnt_base_d;
            wdata_hi_q <= bus.cpu_wdata[15:8];
            addr_q     <= gnt_base_d;
            dout_q     <= bus.cpu_wdata[7:0];
            dout_en_q  <= gnt_wr_d;
            ce_q       <= 1'b0;
            oe_q       <= gnt_wr_d;
            we_q       <= 1'b1;  // clock 0 of a write is address/data setup
          end
        end
        ST_LO: begin
          we_q <= !(wr_q && we_win);
          if (cap) begin
            state_q <= ST_HI;
            addr_q  <= base_q + SRAM_AW'(1);
            dout_q  <= wdata_hi_q;
            if (!wr_q) rd_lo_q <= bus.sram_din;
          end
        end
        ST_HI: begin
          we_q <= !(wr_q && we_win);
          if (cap) begin
            state_q   <= ST_ACK;
            ce_q      <= 1'b1;
            oe_q      <= 1'b1;
            we_q      <= 1'b1;
            dout_en_q <= 1'b0;
            last_q    <= port_q;
            // Commit the whole word at once so rdata never shows a half-updated value.
            if (port_q == PORT_CPU) begin
              cpu_ack_q <= 1'b1;
              if (!wr_q) cpu_rdata_q <= {bus.sram_din, rd_lo_q};
            end else begin
              vid_ack_q   <= 1'b1;
              vid_rdata_q <= {bus.sram_din, rd_lo_q};
            end
          end
        end
        ST_ACK: begin
          cpu_ack_q <= 1'b0;
          vid_ack_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata    = cpu_rdata_q;
  assign bus.cpu_ack      = cpu_ack_q;
  assign bus.vid_rdata    = vid_rdata_q;
  assign bus.vid_ack      = vid_ack_q;
  assign bus.sram_addr    = addr_q;
  assign bus.sram_dout    = dout_q;
  assign bus.sram_dout_en = dout_en_q;
  assign bus.sram_ce      = ce_q;
  assign bus.sram_oe      = oe_q;
  assign bus.sram_we      = we_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural byte-wide SRAM model.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int AC  = 2;
  localparam int LAT = 2*AC + 1;  // clocks from sampling edge to end of ack cycle

  typedef struct {
    logic        is_rd;
    logic [15:0] rdata;
    int          t0;
    bit          chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t  cpu_q[$];
  exp_t  vid_q[$];
  port_e ord_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter_if bus();

  sram_arbiter #(.ACCESS_CYCLES(AC), .VIDEO_BASE(21'h1F0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model: writes on a clock edge while ce/we low, reads combinationally.
  logic [7:0]  mem [0:(1<<21)-1];
  logic        bd_we = 1'b0;
  logic [20:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (!bus.sram_ce && !bus.sram_we && bus.sram_dout_en) mem[bus.sram_addr] <= bus.sram_dout;
  end

  assign bus.sram_din = (!bus.sram_ce && !bus.sram_oe) ? mem[bus.sram_addr] : 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [20:0] a, input logic [7:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1 bd_we = 1'b0;
  endtask

  task automatic wait_ack(input bit vid, input string nm);
    int   n = 0;
    logic a = 1'b0;
    while (!a && n < 40) begin
      @(negedge clk);
      n++;
      a = vid ? bus.vid_ack : bus.cpu_ack;
    end
    check({nm, "_ack_seen"}, 32'(a), 32'd1);
  endtask

  task automatic cpu_access(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                            input logic [15:0] erd, input string nm);
    exp_t e;
    e.is_rd = !wr; e.rdata = erd; e.t0 = cyc + 1; e.chk_lat = 1'b1;
    cpu_q.push_back(e);
    ord_q.push_back(PORT_CPU);
    bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_rd = !wr; bus.cpu_wr = wr;
    wait_ack(1'b0, nm);
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_vid(input logic [15:0] erd, input bit lat);
    exp_t e;
    e.is_rd = 1'b1; e.rdata = erd; e.t0 = cyc + 1; e.chk_lat = lat;
    vid_q.push_back(e);
  endtask

  task automatic push_cpu_rd(input logic [15:0] erd);
    exp_t e;
    e.is_rd = 1'b1; e.rdata = erd; e.t0 = 0; e.chk_lat = 1'b0;
    cpu_q.push_back(e);
  endtask

  task automatic reset_pulse(input string nm);
    rst = 1'b1;
    @(negedge clk);
    check({nm, "_ce"},      32'(bus.sram_ce),      32'd1);
    check({nm, "_oe"},      32'(bus.sram_oe),      32'd1);
    check({nm, "_we"},      32'(bus.sram_we),      32'd1);
    check({nm, "_dout_en"}, 32'(bus.sram_dout_en), 32'd0);
    check({nm, "_acks"},    32'({bus.cpu_ack, bus.vid_ack}), 32'd0);
    check({nm, "_cpu_rdata"}, 32'(bus.cpu_rdata), 32'd0);
    check({nm, "_vid_rdata"}, 32'(bus.vid_rdata), 32'd0);
    #2 rst = 1'b0;
  endtask

  // Monitor: strobe accounting and scoreboard comparison at every ack.
  initial begin : monitor
    int          we_lo, oe_lo;
    logic [15:0] cpu_seen, vid_seen;
    exp_t        e;
    port_e       o;
    we_lo = 0; oe_lo = 0; cpu_seen = '0; vid_seen = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        we_lo = 0; oe_lo = 0; cpu_seen = '0; vid_seen = '0;
      end else begin
        if (!bus.sram_we) we_lo++;
        if (!bus.sram_oe) oe_lo++;
        if (bus.cpu_rd && bus.cpu_wr) check("cpu_rd_wr_exclusive", 32'd1, 32'd0);
        if (bus.cpu_ack) begin
          if (cpu_q.size() == 0) check("cpu_ack_unexpected", 32'(bus.cpu_ack), 32'd0);
          else begin
            e = cpu_q.pop_front();
            if (ord_q.size() != 0) begin
              o = ord_q.pop_front();
              check("grant_order_cpu", 32'(o), 32'(PORT_CPU));
            end
            if (e.is_rd) begin
              check("cpu_rdata", 32'(bus.cpu_rdata), 32'(e.rdata));
              check("cpu_rd_oe_clocks", 32'(oe_lo), 32'(2*AC));
              check("cpu_rd_we_clocks", 32'(we_lo), 32'd0);
              cpu_seen = bus.cpu_rdata;
            end else begin
              check("cpu_wr_we_clocks", 32'(we_lo), 32'(2*(AC-1)));
              check("cpu_wr_oe_clocks", 32'(oe_lo), 32'd0);
              check("cpu_wr_rdata_held", 32'(bus.cpu_rdata), 32'(cpu_seen));
            end
            check("vid_rdata_untouched", 32'(bus.vid_rdata), 32'(vid_seen));
            if (e.chk_lat) check("cpu_latency", 32'(cyc + 1 - e.t0), 32'(LAT));
          end
          we_lo = 0; oe_lo = 0;
        end
        if (bus.vid_ack) begin
          if (vid_q.size() == 0) check("vid_ack_unexpected", 32'(bus.vid_ack), 32'd0);
          else begin
            e = vid_q.pop_front();
            if (ord_q.size() != 0) begin
              o = ord_q.pop_front();
              check("grant_order_vid", 32'(o), 32'(PORT_VID));
            end
            check("vid_rdata", 32'(bus.vid_rdata), 32'(e.rdata));
            check("vid_oe_clocks", 32'(oe_lo), 32'(2*AC));
            check("vid_we_clocks", 32'(we_lo), 32'd0);
            check("cpu_rdata_untouched", 32'(bus.cpu_rdata), 32'(cpu_seen));
            if (e.chk_lat) check("vid_latency", 32'(cyc + 1 - e.t0), 32'(LAT));
            vid_seen = bus.vid_rdata;
          end
          we_lo = 0; oe_lo = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin : stim
    int   n;
    logic hit;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    bus.vid_addr = '0; bus.vid_req = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) poke(21'h1F0000 + 21'(i), 8'h10 + 8'(i));
    poke(21'h1F0006, 8'h5A); poke(21'h1F0007, 8'hC3);
    poke(21'h1F000A, 8'h48); poke(21'h1F000B, 8'h07);
    for (int i = 0; i < 4; i++) poke(21'h22 + 21'(i), 8'hA0 + 8'(i));
    poke(21'h20, 8'h00); poke(21'h21, 8'h00);
    poke(21'h40, 8'h00); poke(21'h41, 8'hAA);
    reset_pulse("reset");
    check("reset_addr", 32'(bus.sram_addr), 32'd0);
    @(negedge clk);

    // 1: CPU write 16'hBEEF @ 16'h0010
    cpu_access(1'b1, 16'h0010, 16'hBEEF, 16'h0000, "t1_wr");
    check("t1_mem_lo", 32'(mem[21'h20]), 32'h0EF);
    check("t1_mem_hi", 32'(mem[21'h21]), 32'h0BE);

    // 2: CPU read back
    cpu_access(1'b0, 16'h0010, 16'h0000, 16'hBEEF, "t2_rd");

    // 3: video read @5 -> bytes 1F000A/B
    push_vid(16'h0748, 1'b1);
    ord_q.push_back(PORT_VID);
    bus.vid_addr = 12'd5; bus.vid_req = 1'b1;
    wait_ack(1'b1, "t3_vid");
    bus.vid_req = 1'b0;
    @(negedge clk);

    // Restore last_grant=CPU so video wins the tie below.
    reset_pulse("reset2");
    @(negedge clk);

    // 4: both ports request together, three words each
    push_vid(16'h1110, 1'b0); push_vid(16'h1312, 1'b0); push_vid(16'h1514, 1'b0);
    push_cpu_rd(16'hBEEF); push_cpu_rd(16'hA1A0); push_cpu_rd(16'hA3A2);
    for (int i = 0; i < 3; i++) begin
      ord_q.push_back(PORT_VID);
      ord_q.push_back(PORT_CPU);
    end
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          bus.vid_addr = 12'(i); bus.vid_req = 1'b1;
          wait_ack(1'b1, "t4_vid");
        end
        bus.vid_req = 1'b0;
      end
      begin
        for (int i = 0; i < 3; i++) begin
          bus.cpu_addr = 16'h0010 + 16'(i); bus.cpu_rd = 1'b1;
          wait_ack(1'b0, "t4_cpu");
        end
        bus.cpu_rd = 1'b0;
      end
    join
    @(negedge clk);

    // 5: reset during HI of a CPU write 16'h1234 @ 16'h0020
    bus.cpu_addr = 16'h0020; bus.cpu_wdata = 16'h1234; bus.cpu_wr = 1'b1;
    n = 0; hit = 1'b0;
    while (!hit && n < 20) begin
      @(negedge clk);
      n++;
      hit = (bus.sram_addr == 21'h41) && !bus.sram_ce;
    end
    check("t5_hi_reached", 32'(hit), 32'd1);
    bus.cpu_wr = 1'b0;
    reset_pulse("t5_rst");
    check("t5_mem_lo", 32'(mem[21'h40]), 32'h034);
    check("t5_mem_hi", 32'(mem[21'h41]), 32'h0AA);
    @(negedge clk);
    cpu_access(1'b0, 16'h0020, 16'h0000, 16'hAA34, "t5_rd");

    // 6: video request dropped one clock after grant
    push_vid(16'hC35A, 1'b1);
    ord_q.push_back(PORT_VID);
    bus.vid_addr = 12'd3; bus.vid_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.vid_req = 1'b0;
    wait_ack(1'b1, "t6_vid");
    repeat (12) @(negedge clk);
    check("t6_idle_ce", 32'(bus.sram_ce), 32'd1);

    check("sb_drained", 32'(cpu_q.size() + vid_q.size() + ord_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
